mem_bus_ctrl: RTL and testbench
===============================

MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: mem_req  in  1  data-access request from control lines, held high by sequencer until mem_done.
REQ-004 SHALL have: mem_we  in  1  1 = store, 0 = load; sampled with mem_req.
REQ-005 SHALL have: size  in  2  access size from fn1[1:0]: 00 byte, 01 word, 10 dword, 11 invalid.
REQ-006 SHALL have: d_addr  in  32  datapath byte address.
REQ-007 SHALL have: dout  in  32  merged store data from datapath (computed from din).
REQ-008 SHALL have: din  out  32  registered read data to datapath.
REQ-009 SHALL have: mem_busy  out  1  stall to sequencer.
REQ-010 SHALL have: mem_done  out  1  one-cycle completion pulse.
REQ-011 SHALL have: mem_err  out  1  one-cycle error pulse, coincident with mem_done.
REQ-012 SHALL have: bus_addr  out  32,  bus_wdata  out  32,  bus_rd  out  1,  bus_wr  out  1,  bus_ack  in  1,  bus_rdata  in  32  -- external word bus.

Function
REQ-013 SHALL implement states IDLE, READ, MERGE, WRITE, DONE, ERR.
REQ-014 IDLE with mem_req=1 SHALL accept: latch bus_addr = {d_addr[31:2],2'b00}, latch mem_we and size.
REQ-015 Accept transitions: load (size 00/01/10) -> READ; store size 00/01 -> READ (read-modify-write); store size 10 -> MERGE; size 11 -> ERR.
REQ-016 READ SHALL drive bus_rd=1 combinationally; on a clock edge with bus_ack=1, din <= bus_rdata; load -> DONE, store -> MERGE.
REQ-017 MERGE SHALL last exactly one cycle, capture dout into bus_wdata, then -> WRITE.
REQ-018 WRITE SHALL drive bus_wr=1; on bus_ack=1 -> DONE.
REQ-019 bus_rd and bus_wr SHALL never be high together and SHALL be 0 outside READ/WRITE.
REQ-020 DONE SHALL assert mem_done for one cycle, then -> IDLE; mem_req in the DONE cycle SHALL be ignored (sequencer drops it on mem_done).
REQ-021 ERR SHALL assert mem_done=1 and mem_err=1 for one cycle, no bus strobe, then -> IDLE; din unchanged.
REQ-022 mem_busy SHALL equal (state in READ/MERGE/WRITE/ERR) or (state==IDLE and mem_req).
REQ-023 bus_ack SHALL be ignored in IDLE, MERGE, DONE, ERR.
REQ-024 Zero-wait latency (cycles from accept edge to mem_done high): load 2, full store 3, partial store 4; each wait cycle on bus_ack adds one.
REQ-025 din SHALL hold its last read value until the next READ ack; bus_addr and bus_wdata SHALL hold until next accept/MERGE.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, din=0, bus_addr=0, bus_wdata=0, bus_rd=0, bus_wr=0, mem_done=0, mem_err=0, timeout counter=0.
REQ-027 Reset mid-transaction SHALL abort it with no completion pulse; mem_busy then follows mem_req only.

Configuration
REQ-028 Macro MEM_TIMEOUT_EN SHALL, when defined, add an 8-bit wait counter cleared on entry to READ/WRITE, incremented each cycle without bus_ack; on reaching 255 without ack the block SHALL drop the strobe and -> ERR.
REQ-029 Without MEM_TIMEOUT_EN, READ/WRITE SHALL wait for bus_ack indefinitely and mem_err SHALL assert only for size 11.

Verification
REQ-030 Load dword, d_addr=0x00000106, bus_ack same cycle, bus_rdata=0xDEADBEEF -> bus_addr=0x00000104, din=0xDEADBEEF, mem_done 2 cycles after accept.
REQ-031 Byte store, d_addr=0x00000011, ack after 3 waits, bus_rdata=0x11223344, dout=0x11AA3344 -> one read then one write to 0x00000010 with bus_wdata=0x11AA3344, mem_done 7 cycles after accept.
REQ-032 Full store, dout=0xCAFEF00D, zero-wait -> no bus_rd, bus_wr one cycle, mem_done 3 cycles after accept.
REQ-033 size=11 with mem_req -> mem_err=mem_done=1 one cycle after accept, bus_rd=bus_wr=0 throughout.
REQ-034 rst_n pulsed low during WRITE -> bus_wr=0 asynchronously, no mem_done, din=0; next request completes normally.
REQ-035 MEM_TIMEOUT_EN defined, bus_ack held 0 during READ -> bus_rd drops and mem_err pulses 256 cycles after READ entry; undefined -> bus_rd stays high.

Source files
------------

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: translates datapath load/store requests into accesses on an
// external 32-bit word bus. Sub-word stores are performed as read-modify-write:
// the current word is read, the datapath merges into it, and the result is
// written back.
// Optional build macro: MEM_TIMEOUT_EN adds an 8-bit bus wait counter that
// aborts a READ/WRITE into ERR after 256 cycles without bus_ack.
module mem_bus_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [1:0]  size,
    input  logic [31:0] d_addr,
    input  logic [31:0] dout,
    output logic [31:0] din,
    output logic        mem_busy,
    output logic        mem_done,
    output logic        mem_err,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_rd,
    output logic        bus_wr,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        MERGE,
        WRITE,
        DONE,
        ERR
    } state_t;

    localparam logic [1:0] SIZE_DWORD   = 2'b10;
    localparam logic [1:0] SIZE_INVALID = 2'b11;

    state_t      state;
    state_t      state_next;
    logic        we_q;
    logic [1:0]  size_q;
    logic        timeout;

    // State register; reset aborts any transaction in flight.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of the order the blocks are evaluated in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request capture, read data return and store data capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_addr  <= '0;
            bus_wdata <= '0;
            din       <= '0;
            we_q      <= 1'b0;
            size_q    <= 2'b00;
        end else begin
            if (state == IDLE && mem_req) begin
                bus_addr <= {d_addr[31:2], 2'b00};
                we_q     <= mem_we;
                size_q   <= size;
            end
            if (state == READ && bus_ack) begin
                din <= bus_rdata;
            end
            if (state == MERGE) begin
                bus_wdata <= dout;
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    logic [7:0] wait_cnt;

    // Wait counter: runs while a strobe is unanswered, cleared outside READ/WRITE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == READ || state == WRITE) begin
            if (!bus_ack) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end else begin
            wait_cnt <= '0;
        end
    end

    assign timeout = (wait_cnt == 8'hFF) && !bus_ack;
`else
    assign timeout = 1'b0;
`endif

    // Next-state and output decode.
    // NOTE: every output gets a default before the case so no path through
    // the block leaves a signal unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        bus_rd     = 1'b0;
        bus_wr     = 1'b0;
        mem_done   = 1'b0;
        mem_err    = 1'b0;
        mem_busy   = 1'b0;
        case (state)
            IDLE: begin
                mem_busy = mem_req;
                if (mem_req) begin
                    if (size == SIZE_INVALID) begin
                        state_next = ERR;
                    end else if (mem_we && size == SIZE_DWORD) begin
                        state_next = MERGE;
                    end else begin
                        state_next = READ;
                    end
                end
            end
            READ: begin
                mem_busy = 1'b1;
                bus_rd   = 1'b1;
                if (bus_ack) begin
                    // Only a sub-word store reaches READ with we set; it
                    // continues into the merge/write-back half.
                    state_next = (we_q && size_q != SIZE_DWORD) ? MERGE : DONE;
                end else if (timeout) begin
                    state_next = ERR;
                end
            end
            MERGE: begin
                mem_busy   = 1'b1;
                state_next = WRITE;
            end
            WRITE: begin
                mem_busy = 1'b1;
                bus_wr   = 1'b1;
                if (bus_ack) begin
                    state_next = DONE;
                end else if (timeout) begin
                    state_next = ERR;
                end
            end
            DONE: begin
                mem_done   = 1'b1;
                state_next = IDLE;
            end
            ERR: begin
                mem_busy   = 1'b1;
                mem_done   = 1'b1;
                mem_err    = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: directed and randomized transactions for mem_bus_ctrl,
// with a bus responder and a transaction-level expectation model.
module tb_mem_bus_ctrl;

    logic        clk;
    logic        rst_n;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  size;
    logic [31:0] d_addr;
    logic [31:0] dout;
    logic [31:0] din;
    logic        mem_busy;
    logic        mem_done;
    logic        mem_err;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_rd;
    logic        bus_wr;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int checks   = 0;
    int failures = 0;

    // Model of architecturally visible registers.
    logic [31:0] m_din;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;

    mem_bus_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .size      (size),
        .d_addr    (d_addr),
        .dout      (dout),
        .din       (din),
        .mem_busy  (mem_busy),
        .mem_done  (mem_done),
        .mem_err   (mem_err),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rd    (bus_rd),
        .bus_wr    (bus_wr),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // One complete transaction. Expectations come from the access type:
    // a read phase (1 + waits) for loads and sub-word stores, a merge plus
    // write phase (2 + waits) for stores, and one completion cycle.
    task automatic run_txn(input string name, input logic we, input logic [1:0] sz,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rdata, input int wait_r, input int wait_w);
        bit is_err, do_read, do_write, overlap, busy_bad, err_seen, busy_done;
        int exp_lat, cyc, done_cyc, rd_seen, wr_seen;
        is_err   = (sz == 2'b11);
        do_write = !is_err && we;
        do_read  = !is_err && !(we && sz == 2'b10);
        exp_lat  = 1 + (do_read ? 1 + wait_r : 0) + (do_write ? 2 + wait_w : 0);
        overlap = 0; busy_bad = 0; err_seen = 0; busy_done = 0;
        done_cyc = 0; rd_seen = 0; wr_seen = 0;

        mem_req = 1'b1; mem_we = we; size = sz; d_addr = addr; dout = wd;
        bus_ack = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
        #1;
        check({name, "_busy_req"}, 32'(mem_busy), 32'd1);
        @(posedge clk); #1;
        cyc = 1;
        while (cyc <= 400 && done_cyc == 0) begin
            if (bus_rd && bus_wr) overlap = 1;
            if (mem_done) begin
                done_cyc  = cyc;
                err_seen  = mem_err;
                busy_done = mem_busy;
                bus_ack   = 1'($urandom_range(0, 1));
            end else begin
                if (!mem_busy) busy_bad = 1;
                if (bus_rd) begin
                    rd_seen++;
                    bus_ack   = (rd_seen == wait_r + 1);
                    bus_rdata = bus_ack ? rdata : $urandom;
                end else if (bus_wr) begin
                    wr_seen++;
                    bus_ack   = (wr_seen == wait_w + 1);
                    bus_rdata = $urandom;
                end else begin
                    // Noise on an idle bus must be ignored.
                    bus_ack   = 1'($urandom_range(0, 1));
                    bus_rdata = $urandom;
                end
                @(posedge clk); #1;
                cyc++;
            end
        end
        check({name, "_latency"}, 32'(done_cyc), 32'(exp_lat));
        check({name, "_err"}, 32'(err_seen), 32'(is_err));
        check({name, "_rd_cycles"}, 32'(rd_seen), do_read ? 32'(wait_r + 1) : 32'd0);
        check({name, "_wr_cycles"}, 32'(wr_seen), do_write ? 32'(wait_w + 1) : 32'd0);
        check({name, "_no_overlap"}, 32'(overlap), 32'd0);
        check({name, "_busy_during"}, 32'(busy_bad), 32'd0);
        check({name, "_busy_done"}, 32'(busy_done), 32'(is_err));

        // mem_req stays high through the completion cycle and must not
        // start a new access.
        @(posedge clk); #1;
        mem_req = 1'b0; bus_ack = 1'b0;
        m_addr = {addr[31:2], 2'b00};
        if (do_read) m_din = rdata;
        if (do_write) m_wdata = wd;
        #1;
        check({name, "_idle_strobes"}, {30'd0, bus_rd, bus_wr}, 32'd0);
        check({name, "_idle_done"}, 32'(mem_done), 32'd0);
        check({name, "_busy_idle"}, 32'(mem_busy), 32'd0);
        check({name, "_din"}, din, m_din);
        check({name, "_bus_addr"}, bus_addr, m_addr);
        check({name, "_bus_wdata"}, bus_wdata, m_wdata);
    endtask

    // Reset asserted while the write strobe is up.
    task automatic reset_during_write();
        int cyc;
        mem_req = 1'b1; mem_we = 1'b1; size = 2'b10; d_addr = 32'h0000_0200;
        dout = 32'h5555_AAAA; bus_ack = 1'b0;
        @(posedge clk); #1;
        cyc = 1;
        while (!bus_wr && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("rst_wr_seen", 32'(bus_wr), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_wr_drop", 32'(bus_wr), 32'd0);
        check("rst_no_done", 32'(mem_done), 32'd0);
        check("rst_din", din, 32'd0);
        check("rst_addr", bus_addr, 32'd0);
        check("rst_wdata", bus_wdata, 32'd0);
        check("rst_busy_req", 32'(mem_busy), 32'd1);
        mem_req = 1'b0;
        #1;
        check("rst_busy_noreq", 32'(mem_busy), 32'd0);
        @(posedge clk); #1;
        check("rst_held_done", 32'(mem_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_din = '0; m_addr = '0; m_wdata = '0;
        @(posedge clk); #1;
    endtask

    // Load whose read is never acknowledged.
    task automatic stalled_read();
        int cyc, rd_cnt, done_cyc;
        bit err_seen;
        rd_cnt = 0; done_cyc = 0; err_seen = 0;
        mem_req = 1'b1; mem_we = 1'b0; size = 2'b10; d_addr = 32'h0000_0300;
        bus_ack = 1'b0;
        @(posedge clk); #1;
        for (cyc = 1; cyc <= 300; cyc++) begin
            if (mem_done) begin
                done_cyc = cyc;
                err_seen = mem_err;
                break;
            end
            if (bus_rd) rd_cnt++;
            @(posedge clk); #1;
        end
`ifdef MEM_TIMEOUT_EN
        check("to_rd_cycles", 32'(rd_cnt), 32'd256);
        check("to_done_cyc", 32'(done_cyc), 32'd257);
        check("to_err", 32'(err_seen), 32'd1);
        check("to_rd_low", 32'(bus_rd), 32'd0);
        @(posedge clk); #1;
        mem_req = 1'b0;
        #1;
        check("to_din_kept", din, m_din);
`else
        check("nto_rd_cycles", 32'(rd_cnt), 32'd300);
        check("nto_no_done", 32'(done_cyc), 32'd0);
        check("nto_rd_high", 32'(bus_rd), 32'd1);
        bus_ack = 1'b1; bus_rdata = 32'h0BAD_F00D;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        check("nto_done", 32'(mem_done), 32'd1);
        check("nto_err", 32'(mem_err), 32'd0);
        @(posedge clk); #1;
        mem_req = 1'b0;
        m_din = 32'h0BAD_F00D;
        #1;
        check("nto_din", din, m_din);
`endif
        m_addr = 32'h0000_0300;
        check("stall_addr", bus_addr, m_addr);
    endtask

    initial begin
        logic        r_we;
        logic [1:0]  r_sz;
        rst_n = 1'b0; mem_req = 1'b0; mem_we = 1'b0; size = 2'b00;
        d_addr = '0; dout = '0; bus_ack = 1'b0; bus_rdata = '0;
        m_din = '0; m_addr = '0; m_wdata = '0;
        #12;
        check("reset_din", din, 32'd0);
        check("reset_addr", bus_addr, 32'd0);
        check("reset_wdata", bus_wdata, 32'd0);
        check("reset_outs", {27'd0, bus_rd, bus_wr, mem_done, mem_err, mem_busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_txn("load_dword", 1'b0, 2'b10, 32'h0000_0106, 32'h0, 32'hDEAD_BEEF, 0, 0);
        run_txn("byte_store", 1'b1, 2'b00, 32'h0000_0011, 32'h11AA_3344, 32'h1122_3344, 3, 0);
        run_txn("full_store", 1'b1, 2'b10, 32'h0000_0020, 32'hCAFE_F00D, 32'h0, 0, 0);
        run_txn("bad_size", 1'b0, 2'b11, 32'h0000_0033, 32'h0, 32'h0, 0, 0);
        run_txn("bad_store", 1'b1, 2'b11, 32'h0000_0047, 32'h1234_5678, 32'h0, 0, 0);
        run_txn("word_store", 1'b1, 2'b01, 32'h0000_0052, 32'h7777_8888, 32'h9999_0000, 1, 2);

        reset_during_write();
        run_txn("post_reset", 1'b0, 2'b01, 32'h0000_0404, 32'h0, 32'hA5A5_5A5A, 1, 0);

        stalled_read();

        for (int i = 0; i < 40; i++) begin
            r_we = 1'($urandom_range(0, 1));
            r_sz = 2'($urandom_range(0, 3));
            run_txn($sformatf("rnd%0d", i), r_we, r_sz, $urandom, $urandom, $urandom,
                    $urandom_range(0, 4), $urandom_range(0, 4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
